alu_op_sched: RTL and testbench

ALU_OP_SCHED -- requirements
Module: alu_op_sched

---
 rtl/alu_sched_pkg.sv | 33 +++
 rtl/alu_op_sched_rr_arb2.sv | 45 ++++
 rtl/alu_op_sched.sv | 163 ++++++++++++++++
 tb/tb_alu_op_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched_pkg
//  Description : Shared types and constants for the ALU operation scheduler:
//                FSM state encoding, ALU function codes of interest, the
//                execution counter width and an execution-latency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

    // Scheduler FSM states; only one operation is ever in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ALU function codes the scheduler needs to know about
    localparam logic [3:0] F_MUL   = 4'b0111;
    localparam logic [3:0] F_SLT   = 4'b1000;
    localparam logic [3:0] F_SHIFT = 4'b1010;

    // Execution counter width; large enough for a multiply latency of 15
    localparam int CNT_W = 4;

    // Number of EXEC cycles an operation with function code f occupies
    function automatic logic [CNT_W-1:0] exec_lat(input logic [3:0]       f,
                                                  input logic [CNT_W-1:0] mul_lat);
        return (f == F_MUL) ? mul_lat : CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input arbiter producing a one-hot grant. A lone valid
//                requester is always granted. With both valid, the requester
//                named by the pointer wins (round-robin), or, when the macro
//                ALU_SCHED_PRIO_EN is defined, requester 0 always wins and the
//                pointer is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

`ifdef ALU_SCHED_PRIO_EN
    // Pointer has no role in fixed-priority mode
    logic w_unused_ptr;
    assign w_unused_ptr = ptr_i;

    // Fixed priority: requester 0 beats requester 1
    always_comb begin
        grant_o = 2'b00;
        if (valid_i[0]) begin
            grant_o = 2'b01;
        end else if (valid_i[1]) begin
            grant_o = 2'b10;
        end
    end
`else
    // Round-robin: contention resolved in favour of the pointer side
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sched
//  Description : Schedules operations from two requesters onto one external
//                combinational ALU. Accepts one operation at a time, drives
//                registered operands to the ALU for a function-dependent
//                number of cycles, captures the result and holds it until the
//                response handshake completes.
//                Optional macro ALU_SCHED_PRIO_EN selects fixed-priority
//                arbitration (requester 0 wins) instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_f,
    input  logic [2:0]  req0_sf,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_f,
    input  logic [2:0]  req1_sf,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_f,
    output logic [2:0]  alu_sf,
    input  logic [31:0] alu_y,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y
);

    localparam logic [CNT_W-1:0] c_mul_lat = CNT_W'(MUL_LAT);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [3:0]         alu_f_q, alu_f_d;
    logic [2:0]         alu_sf_q, alu_sf_d;
    logic [31:0]        rsp_y_q, rsp_y_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;

    logic [1:0]         w_grant;
    logic               w_idle;
    logic               w_sel;

    rr_arb2 u_arb (
        .valid_i (({req1_valid, req0_valid})),
        .ptr_i   (ptr_q),
        .grant_o (w_grant)
    );

    // Ready only reflects the grant while idle; forced low in the reset cycle
    assign w_idle     = (state_q == ST_IDLE);
    assign req0_ready = w_idle & w_grant[0] & ~rst;
    assign req1_ready = w_idle & w_grant[1] & ~rst;
    assign w_sel      = w_grant[1];

    // Next-state logic: accept, count down execution, hold response
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f_d     = alu_f_q;
        alu_sf_d    = alu_sf_q;
        rsp_y_d     = rsp_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;

        case (state_q)
            ST_IDLE: begin
                if (|w_grant) begin
                    alu_a_d  = w_sel ? req1_a  : req0_a;
                    alu_b_d  = w_sel ? req1_b  : req0_b;
                    alu_f_d  = w_sel ? req1_f  : req0_f;
                    alu_sf_d = w_sel ? req1_sf : req0_sf;
                    rsp_id_d = w_sel;
                    cnt_d    = exec_lat(w_sel ? req1_f : req0_f, c_mul_lat);
`ifndef ALU_SCHED_PRIO_EN
                    ptr_d    = ~w_sel;
`endif
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A count of 0 cannot occur here but is treated as done
                if (cnt_q <= CNT_W'(1)) begin
                    rsp_y_d     = alu_y;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset discarding any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            alu_sf_q    <= '0;
            rsp_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            alu_sf_q    <= alu_sf_d;
            rsp_y_q     <= rsp_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign alu_sf    = alu_sf_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sched
//  Description : Directed self-checking bench for alu_op_sched, with a small
//                behavioural ALU closing the alu_* / alu_y loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sched;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_f, req1_f;
    logic [2:0]  req0_sf, req1_sf;
    logic [31:0] alu_a, alu_b, alu_y, rsp_y;
    logic [3:0]  alu_f;
    logic [2:0]  alu_sf;
    logic        rsp_valid, rsp_ready, rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sched #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req0_sf    (req0_sf),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .req1_sf    (req1_sf),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_sf     (alu_sf),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y)
    );

    // Behavioural ALU: add, sub, mul, signed SLT; anything else yields 0
    always_comb begin
        alu_y = 32'd0;
        case (alu_f)
            4'b0000: alu_y = alu_a + alu_b;
            4'b0001: alu_y = alu_a - alu_b;
            4'b0111: alu_y = alu_a * alu_b;
            4'b1000: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = 32'd0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on a port and check latency, result and ownership
    task automatic do_op(input string tag, input logic port,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [2:0] sf,
                         input logic [31:0] exp_y, input int exp_lat);
        int   n;
        logic seen;
        rsp_ready = 1'b1;
        if (port == 1'b0) begin
            req0_a = a; req0_b = b; req0_f = f; req0_sf = sf; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_f = f; req1_sf = sf; req1_valid = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = port ? req1_ready : req0_ready;
        end
        check_eq({tag, "_grant"}, seen, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (seen) begin
            n    = 0;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                n++;
                seen = rsp_valid;
            end
            check_eq({tag, "_rsp_seen"}, seen, 1);
            check_eq({tag, "_latency"}, n, exp_lat + 1);
            check_eq({tag, "_rsp_y"}, rsp_y, exp_y);
            check_eq({tag, "_rsp_id"}, rsp_id, port);
            check_eq({tag, "_alu_f"}, alu_f, f);
            check_eq({tag, "_alu_sf"}, alu_sf, sf);
            @(posedge clk); #1;
        end
    endtask

    int   ng;
    logic got;
    logic grants [4];
    logic exp_order [4];

    initial begin
`ifdef ALU_SCHED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        req0_a = 0; req0_b = 0; req0_f = 0; req0_sf = 0;
        req1_a = 0; req1_b = 0; req1_f = 0; req1_sf = 0;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;

        // Reset with both requesters valid: no ready during reset
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy0", req0_ready, 0);
        check_eq("rst_rdy1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_f", alu_f, 0);
        check_eq("rst_rsp_y", rsp_y, 0);
        check_eq("rst_rsp_id", rsp_id, 0);

        // Single operations with hand-computed results
        do_op("slt",     1'b0, 32'd5, 32'd3, 4'b1000, 3'b000, 32'd0, 1);
        do_op("mul",     1'b1, 32'd7, 32'd6, 4'b0111, 3'b000, 32'd42, MUL_LAT);
        do_op("unsup",   1'b0, 32'd3, 32'd4, 4'b1001, 3'b101, 32'd0, 1);
        do_op("sub_neg", 1'b1, 32'd2, 32'd5, 4'b0001, 3'b010, 32'hFFFF_FFFD, 1);

        // Idle with no valids: nothing moves, operands hold last operation
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ready", {req1_ready, req0_ready}, 0);
            check_eq("idle_rsp_valid", rsp_valid, 0);
            check_eq("idle_alu_a", alu_a, 32'd2);
            check_eq("idle_alu_b", alu_b, 32'd5);
            check_eq("idle_alu_f", alu_f, 4'b0001);
        end

        // Arbitration order with both requesters valid continuously
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_a = 32'd1;  req0_b = 32'd2;  req0_f = 4'b0000;
        req1_a = 32'd10; req1_b = 32'd20; req1_f = 4'b0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        ng = 0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) check_eq("arb_onehot", {req1_ready, req0_ready}, 2'b01);
            if (req0_ready || req1_ready) begin
                grants[ng] = req1_ready;
                ng++;
            end
        end
        check_eq("arb_count", ng, 4);
        for (int i = 0; i < ng; i++) check_eq($sformatf("arb_grant%0d", i), grants[i], exp_order[i]);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Response back-pressure: outputs stable, no ready while busy
        rsp_ready  = 1'b0;
        req0_a = 32'd100; req0_b = 32'd1; req0_f = 4'b0001;
        req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
        end
        check_eq("bp_grant", got, 1);
        @(posedge clk); #1;
        req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check_eq("bp_rsp_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", rsp_valid, 1);
            check_eq("bp_rsp_y", rsp_y, 32'd99);
            check_eq("bp_rsp_id", rsp_id, 0);
            check_eq("bp_ready", {req1_ready, req0_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_after_rsp_valid", rsp_valid, 0);
`ifdef ALU_SCHED_PRIO_EN
        check_eq("bp_resume_ready", {req1_ready, req0_ready}, 2'b01);
`else
        check_eq("bp_resume_ready", {req1_ready, req0_ready}, 2'b10);
`endif
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during multiply execution discards the operation
        req0_a = 32'd7; req0_b = 32'd6; req0_f = 4'b0111; req0_sf = 3'b011;
        req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
        end
        check_eq("rx_grant", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rx_rdy_in_rst", req0_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("rx_rsp_valid", rsp_valid, 0);
        check_eq("rx_alu_a", alu_a, 0);
        check_eq("rx_alu_b", alu_b, 0);
        check_eq("rx_alu_f", alu_f, 0);
        check_eq("rx_alu_sf", alu_sf, 0);
        check_eq("rx_rsp_y", rsp_y, 0);
        check_eq("rx_rsp_id", rsp_id, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rx_no_rsp", rsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
